// File: rtl/range_class_filter_pkg.sv
// Shared definitions for the range-class debounce filter: class encoding,
// class type and filter FSM state.
package range_class_filter_pkg;

  localparam logic [1:0] CLASS_LOW    = 2'd0;
  localparam logic [1:0] CLASS_MID_LO = 2'd1;
  localparam logic [1:0] CLASS_MID_HI = 2'd2;
  localparam logic [1:0] CLASS_HIGH   = 2'd3;

  typedef logic [1:0] range_class_t;

  typedef enum logic {
    STABLE = 1'b0,
    CAND   = 1'b1
  } filt_state_t;

endpackage

// File: rtl/range_class_filter_if.sv
// Sample/class bus between range_classifier consumer logic and the filter.
interface range_class_filter_if;
  import range_class_filter_pkg::*;

  logic         tick;
  range_class_t class_in;
  range_class_t class_out;
  logic         changed;
  logic         dir_up;
  logic         pending;

  modport master (output tick, class_in, input class_out, changed, dir_up, pending);
  modport slave  (input tick, class_in, output class_out, changed, dir_up, pending);

endinterface

// File: rtl/range_class_filter_hold_counter.sv
// Agreement counter for the candidate class; tc flags HOLD-1 agreeing samples,
// so the next agreeing sample is the committing one.
module range_class_filter_hold_counter #(
  parameter int HOLD = 3,
  localparam int CW  = $clog2(HOLD + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic start,
  input  logic inc,
  output logic tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (start) cnt <= CW'(1);
    else if (inc)   cnt <= cnt + CW'(1);
  end

  assign tc = (cnt == CW'(HOLD - 1));

endmodule

// File: rtl/range_class_filter.sv
// Debounce/hysteresis filter on the 2-bit range class; commits after HOLD agreeing ticks.
// RANGE_FILTER_STEP_LIMIT_EN: each commit moves class_out one level toward the candidate.
module range_class_filter
  import range_class_filter_pkg::*;
#(
  parameter int           HOLD        = 3,
  parameter range_class_t RESET_CLASS = CLASS_LOW
) (
  input  logic                 clk,
  input  logic                 rst,
  range_class_filter_if.slave  bus
);

  filt_state_t  state;
  range_class_t cand;
  range_class_t target;
  range_class_t next_class;
  logic         differs, agrees, tc;
  logic         commit, cnt_clr, cnt_start, cnt_inc;

  assign differs = (bus.class_in != bus.class_out);
  assign agrees  = (bus.class_in == cand);
  assign bus.pending = (state == CAND);

  always_comb begin
    commit    = 1'b0;
    target    = cand;
    cnt_clr   = 1'b0;
    cnt_start = 1'b0;
    cnt_inc   = 1'b0;
    if (bus.tick) begin
      case (state)
        STABLE: if (differs) begin
          target = bus.class_in;
          if (HOLD == 1) commit    = 1'b1;
          else           cnt_start = 1'b1;
        end
        CAND: begin
          if (!differs)     cnt_clr   = 1'b1;
          else if (!agrees) cnt_start = 1'b1;
          else if (tc) begin
            commit  = 1'b1;
            cnt_clr = 1'b1;
          end
          else              cnt_inc   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // commit only fires when target differs from class_out, so the step never wraps
`ifdef RANGE_FILTER_STEP_LIMIT_EN
  assign next_class = (target > bus.class_out) ? bus.class_out + 2'd1 : bus.class_out - 2'd1;
`else
  assign next_class = target;
`endif

  range_class_filter_hold_counter #(.HOLD(HOLD)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .start (cnt_start),
    .inc   (cnt_inc),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= STABLE;
      cand          <= CLASS_LOW;
      bus.class_out <= RESET_CLASS;
      bus.changed   <= 1'b0;
      bus.dir_up    <= 1'b0;
    end else begin
      bus.changed <= commit;
      if (commit) begin
        bus.class_out <= next_class;
        bus.dir_up    <= (target > bus.class_out);
      end
      if (bus.tick) begin
        case (state)
          STABLE: if (differs && HOLD != 1) begin
            cand  <= bus.class_in;
            state <= CAND;
          end
          CAND: begin
            if (!differs || (agrees && tc)) state <= STABLE;
            else if (!agrees)               cand  <= bus.class_in;
          end
          default: state <= STABLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_range_class_filter.sv
// Self-checking bench for range_class_filter (HOLD=3, RESET_CLASS=0) against a
// run-length reference model of the debounce rules.
module tb_range_class_filter;
  import range_class_filter_pkg::*;

  localparam int HOLD = 3;
`ifdef RANGE_FILTER_STEP_LIMIT_EN
  localparam bit STEP_LIMIT = 1'b1;
`else
  localparam bit STEP_LIMIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  range_class_filter_if bus();

  range_class_filter #(.HOLD(HOLD), .RESET_CLASS(2'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: committed class plus the current run of identical differing samples
  int m_class, m_dir, m_changed, run_val, run_len;

  logic [4:0] got_v;
  assign got_v = {bus.class_out, bus.changed, bus.dir_up, bus.pending};

  function automatic logic [4:0] exp_vec();
    return {m_class[1:0], m_changed[0], m_dir[0], run_len > 0};
  endfunction

  task automatic model_reset();
    m_class = 0; m_dir = 0; m_changed = 0; run_val = 0; run_len = 0;
  endtask

  task automatic model_tick(input logic tk, input logic [1:0] c);
    m_changed = 0;
    if (tk) begin
      if (int'(c) == m_class) run_len = 0;
      else begin
        if (run_len > 0 && int'(c) == run_val) run_len++;
        else begin
          run_val = int'(c);
          run_len = 1;
        end
        if (run_len >= HOLD) begin
          m_dir = (run_val > m_class) ? 1 : 0;
          if (STEP_LIMIT) m_class = (run_val > m_class) ? m_class + 1 : m_class - 1;
          else            m_class = run_val;
          m_changed = 1;
          run_len = 0;
        end
      end
    end
  endtask

  // drive one clock, advance the model, land 1 time unit after the edge
  task automatic cycle(input logic tk, input logic [1:0] c);
    bus.tick = tk;
    bus.class_in = c;
    @(posedge clk);
    model_tick(tk, c);
    #1;
  endtask

  task automatic apply_reset();
    bus.tick = 1'b0;
    bus.class_in = 2'd0;
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    model_reset();
    cycle(1'b0, 2'd0);
  endtask

  task automatic test_reset();
    bus.tick = 1'b0;
    bus.class_in = 2'd0;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (got_v !== 5'b0) begin
      failures++; $display("FAIL reset_initial got=%b exp=%b", got_v, 5'b0);
    end
    #3 rst = 1'b0;
    cycle(1'b0, 2'd0);
    // build up dir_up=1 and a live candidate, then reset between clock edges
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd2);
    cycle(1'b1, 2'd1);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (got_v !== 5'b0) begin
      failures++; $display("FAIL reset_async got=%b exp=%b", got_v, 5'b0);
    end
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'd1);
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL reset_discard i=%0d got=%b exp=%b", i, got_v, exp_vec());
      end
    end
  endtask

  task automatic test_clean_step();
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 2'd2);
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL clean_step i=%0d got=%b exp=%b", i, got_v, exp_vec());
      end
      if (i == 1) begin
        checks++;
        if (bus.pending !== 1'b1) begin
          failures++; $display("FAIL clean_pending got=%b exp=1", bus.pending);
        end
      end
      if (i == 3) begin
        checks++;
        if (bus.class_out !== (STEP_LIMIT ? 2'd1 : 2'd2) || bus.changed !== 1'b1 || bus.dir_up !== 1'b1) begin
          failures++; $display("FAIL clean_commit class=%0d changed=%b dir=%b", bus.class_out, bus.changed, bus.dir_up);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [1:0] seq [4];
    int pulses;
    seq = '{2'd1, 2'd1, 2'd0, 2'd0};
    pulses = 0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, seq[i]);
      pulses += int'(bus.changed);
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL glitch i=%0d got=%b exp=%b", i, got_v, exp_vec());
      end
    end
    checks++;
    if (pulses != 0 || bus.class_out !== 2'd0) begin
      failures++; $display("FAIL glitch_nocommit pulses=%0d class=%0d exp 0/0", pulses, bus.class_out);
    end
  endtask

  task automatic test_cand_swap();
    logic [1:0] seq [5];
    seq = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, seq[i]);
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL cand_swap i=%0d got=%b exp=%b", i, got_v, exp_vec());
      end
    end
  endtask

  task automatic test_tick_gating();
    int pulses;
    pulses = 0;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(i % 4 == 3, 2'd2);
      pulses += int'(bus.changed);
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL tick_gating i=%0d got=%b exp=%b", i, got_v, exp_vec());
      end
    end
    checks++;
    if (pulses != 1 || bus.changed !== 1'b1) begin
      failures++; $display("FAIL tick_gating_commit pulses=%0d changed=%b exp 1/1", pulses, bus.changed);
    end
  endtask

  task automatic test_step_limit();
    int pulses;
    pulses = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 2'd3);
      pulses += int'(bus.changed);
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL step i=%0d got=%b exp=%b", i, got_v, exp_vec());
      end
    end
    checks++;
    if (pulses != (STEP_LIMIT ? 3 : 1) || bus.class_out !== 2'd3) begin
      failures++; $display("FAIL step_pulses pulses=%0d class=%0d exp %0d/3", pulses, bus.class_out, STEP_LIMIT ? 3 : 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] lv [4];
    lv = '{2'd3, 2'd0, 2'd1, 2'd2};
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, lv[i / 3]);
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL back_to_back i=%0d got=%b exp=%b", i, got_v, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] c;
    logic tk;
    c = 2'd0;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) c = 2'($urandom_range(0, 3));
      tk = ($urandom_range(0, 3) != 0);
      cycle(tk, c);
      checks++;
      if (got_v !== exp_vec()) begin
        failures++; $display("FAIL random i=%0d got=%b exp=%b", i, got_v, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_cand_swap();
    test_tick_gating();
    test_step_limit();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
